// File: rtl/hdmi_pkg.sv
// Shared types and constants for the HDMI line prefetch address generator.
package hdmi_pkg;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ISSUE} state_t;

    localparam int unsigned BYTES_PER_WORD = 4;
    // Wide enough for word and line counters up to 4095 plus one.
    localparam int unsigned CNT_W = 13;

endpackage

// File: rtl/hdmi_addr_calc.sv
// Registered burst address: base + fb*FB_STRIDE + y*LINE_STRIDE + word*4, one cycle latency.
module hdmi_addr_calc
    import hdmi_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter logic [31:0] LINE_STRIDE = 32'h0000_0400,
    parameter logic [31:0] FB_STRIDE   = 32'h0010_0000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [1:0]       fb,
    input  logic [CNT_W-1:0] y,
    input  logic [CNT_W-1:0] word,
    output logic [31:0]      addr
);

    logic [31:0] addr_d;

    always_comb begin
        addr_d = BASE_ADDR + 32'(fb) * FB_STRIDE + 32'(y) * LINE_STRIDE
               + 32'(word) * BYTES_PER_WORD;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr <= '0;
        end else if (en) begin
            addr <= addr_d;
        end
    end

endmodule

// File: rtl/hdmi_line_fetch.sv
// Issues one image line of DRAM read bursts per prefetch_line over a kick/busy handshake.
module hdmi_line_fetch
    import hdmi_pkg::*;
#(
    parameter int unsigned X_SIZE      = 256,
    parameter int unsigned Y_SIZE      = 256,
    parameter int unsigned BURST_WORDS = 64,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter logic [31:0] LINE_STRIDE = 32'h0000_0400,
    parameter logic [31:0] FB_STRIDE   = 32'h0010_0000,
    parameter int unsigned NUM_FB      = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        framestart,
    input  logic        prefetch_line,
    input  logic [1:0]  fb_sel,
    input  logic        busy,
    output logic        kick,
    output logic [31:0] read_addr,
    output logic [31:0] read_num,
    output logic [1:0]  cur_fb,
    output logic        line_done,
    output logic        frame_done,
    output logic        overrun
);

    localparam logic [CNT_W-1:0] LW     = CNT_W'(X_SIZE);
    localparam logic [CNT_W-1:0] BURST  = CNT_W'(BURST_WORDS);
    localparam logic [CNT_W-1:0] Y_END  = CNT_W'(Y_SIZE);
    localparam logic [1:0]       FB_MAX = 2'(NUM_FB - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] word_cnt_q, word_cnt_d, y_q, y_d, burst_q;
    logic [CNT_W-1:0] remain, burst_len, word_sum, y_inc;
    logic [1:0]       cur_fb_q, cur_fb_d, fb_clamped;
    logic             abort_q, abort_d, overrun_q, overrun_d;
    logic             line_done_q, line_done_d, frame_done_q, frame_done_d;
    logic             calc_en;

    assign fb_clamped = (fb_sel > FB_MAX) ? FB_MAX : fb_sel;
    assign remain     = LW - word_cnt_q;
    assign burst_len  = (remain < BURST) ? remain : BURST;
    assign word_sum   = word_cnt_q + burst_q;
    assign y_inc      = y_q + CNT_W'(1);
    // Freeze address and length while a burst is offered so they stay stable under kick.
    assign calc_en    = (state_q != S_ISSUE);

    hdmi_addr_calc #(
        .BASE_ADDR   (BASE_ADDR),
        .LINE_STRIDE (LINE_STRIDE),
        .FB_STRIDE   (FB_STRIDE)
    ) u_addr_calc (
        .clk  (clk),
        .rst  (rst),
        .en   (calc_en),
        .fb   (cur_fb_q),
        .y    (y_q),
        .word (word_cnt_q),
        .addr (read_addr)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            word_cnt_q   <= '0;
            y_q          <= '0;
            cur_fb_q     <= '0;
            abort_q      <= 1'b0;
            overrun_q    <= 1'b0;
            line_done_q  <= 1'b0;
            frame_done_q <= 1'b0;
            burst_q      <= '0;
        end else begin
            state_q      <= state_d;
            word_cnt_q   <= word_cnt_d;
            y_q          <= y_d;
            cur_fb_q     <= cur_fb_d;
            abort_q      <= abort_d;
            overrun_q    <= overrun_d;
            line_done_q  <= line_done_d;
            frame_done_q <= frame_done_d;
            if (calc_en) begin
                burst_q <= burst_len;
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        word_cnt_d   = word_cnt_q;
        y_d          = y_q;
        cur_fb_d     = cur_fb_q;
        abort_d      = abort_q;
        overrun_d    = overrun_q;
        line_done_d  = 1'b0;
        frame_done_d = 1'b0;

        if (prefetch_line && state_q != S_IDLE) begin
            overrun_d = 1'b1;
        end
        if (framestart) begin
            y_d      = '0;
            cur_fb_d = fb_clamped;
        end

        unique case (state_q)
            S_IDLE: begin
                if (!framestart && prefetch_line && y_q < Y_END) begin
                    word_cnt_d = '0;
                    state_d    = S_WAIT;
                end
            end
            S_WAIT: begin
                if (framestart) begin
                    state_d = S_IDLE;
                end else if (!busy) begin
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                // A framestart here is remembered; the pending burst still completes its handshake.
                if (framestart) begin
                    abort_d = 1'b1;
                end
                if (busy) begin
                    word_cnt_d = word_sum;
                    abort_d    = 1'b0;
                    if (abort_q || framestart) begin
                        state_d = S_IDLE;
                    end else if (word_sum == LW) begin
                        line_done_d  = 1'b1;
                        y_d          = y_inc;
                        frame_done_d = (y_inc == Y_END);
                        state_d      = S_IDLE;
                    end else begin
                        state_d = S_WAIT;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        kick       = (state_q == S_ISSUE);
        read_num   = {{(32 - CNT_W){1'b0}}, burst_q};
        cur_fb     = cur_fb_q;
        line_done  = line_done_q;
        frame_done = frame_done_q;
        overrun    = overrun_q;
    end

endmodule

// File: tb/tb_hdmi_line_fetch.sv
// Directed bench: three hdmi_line_fetch instances (defaults, X_SIZE=200, Y_SIZE=2).
module tb_hdmi_line_fetch;
    import hdmi_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        framestart, prefetch_line, clr;
    logic [1:0]  fb_sel;
    logic [2:0]  busy, busy_auto, busy_man, manual;
    logic [2:0]  kick, line_done, frame_done, overrun;
    logic [31:0] read_addr [3];
    logic [31:0] read_num [3];
    logic [1:0]  cur_fb [3];
    logic [31:0] cap_addr [3][8];
    logic [31:0] cap_num [3][8];
    int          cnt [3];
    int          n_acc [3];
    int          n_ld [3];
    int          n_fd [3];
    int          fd_bad [3];
    int          ld_after [3];
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    assign busy = (manual & busy_man) | (~manual & busy_auto);

    hdmi_line_fetch dut_a (
        .clk(clk), .rst(rst), .framestart(framestart), .prefetch_line(prefetch_line),
        .fb_sel(fb_sel), .busy(busy[0]), .kick(kick[0]), .read_addr(read_addr[0]),
        .read_num(read_num[0]), .cur_fb(cur_fb[0]), .line_done(line_done[0]),
        .frame_done(frame_done[0]), .overrun(overrun[0])
    );

    hdmi_line_fetch #(.X_SIZE(200)) dut_b (
        .clk(clk), .rst(rst), .framestart(framestart), .prefetch_line(prefetch_line),
        .fb_sel(fb_sel), .busy(busy[1]), .kick(kick[1]), .read_addr(read_addr[1]),
        .read_num(read_num[1]), .cur_fb(cur_fb[1]), .line_done(line_done[1]),
        .frame_done(frame_done[1]), .overrun(overrun[1])
    );

    hdmi_line_fetch #(.Y_SIZE(2)) dut_c (
        .clk(clk), .rst(rst), .framestart(framestart), .prefetch_line(prefetch_line),
        .fb_sel(fb_sel), .busy(busy[2]), .kick(kick[2]), .read_addr(read_addr[2]),
        .read_num(read_num[2]), .cur_fb(cur_fb[2]), .line_done(line_done[2]),
        .frame_done(frame_done[2]), .overrun(overrun[2])
    );

    // DRAM reader model: raises busy for one cycle three cycles after kick rises.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_auto <= '0;
            for (int i = 0; i < 3; i++) cnt[i] <= 0;
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (busy_auto[i]) begin
                    busy_auto[i] <= 1'b0;
                    cnt[i]       <= 0;
                end else if (kick[i]) begin
                    if (cnt[i] == 2) busy_auto[i] <= 1'b1;
                    cnt[i] <= cnt[i] + 1;
                end
            end
        end
    end

    // Records every accepted burst and the completion pulses.
    always @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (clr) begin
                n_acc[i]    <= 0;
                n_ld[i]     <= 0;
                n_fd[i]     <= 0;
                fd_bad[i]   <= 0;
                ld_after[i] <= 0;
            end else begin
                if (kick[i] && busy[i]) begin
                    if (n_acc[i] < 8) begin
                        cap_addr[i][n_acc[i][2:0]] <= read_addr[i];
                        cap_num[i][n_acc[i][2:0]]  <= read_num[i];
                    end
                    n_acc[i] <= n_acc[i] + 1;
                end
                if (line_done[i]) begin
                    n_ld[i]     <= n_ld[i] + 1;
                    ld_after[i] <= n_acc[i];
                end
                if (frame_done[i]) n_fd[i] <= n_fd[i] + 1;
                if (frame_done[i] && !line_done[i]) fd_bad[i] <= fd_bad[i] + 1;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic pulse_fs(input logic [1:0] sel);
        @(negedge clk);
        fb_sel     = sel;
        framestart = 1'b1;
        @(negedge clk);
        framestart = 1'b0;
    endtask

    task automatic pulse_pf();
        @(negedge clk);
        prefetch_line = 1'b1;
        @(negedge clk);
        prefetch_line = 1'b0;
    endtask

    task automatic clear();
        @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
    endtask

    task automatic wait_ld(input int i, input int target);
        int k = 0;
        while (n_ld[i] < target && k < 300) begin
            @(negedge clk);
            k++;
        end
        check($sformatf("line_done_count[%0d]", i), n_ld[i], target);
    endtask

    task automatic wait_kick(input int i);
        int k = 0;
        while (!kick[i] && k < 50) begin
            @(negedge clk);
            k++;
        end
        check($sformatf("kick_rise[%0d]", i), 32'(kick[i]), 1);
    endtask

    initial begin
        rst           = 1'b0;
        clr           = 1'b1;
        framestart    = 1'b0;
        prefetch_line = 1'b0;
        fb_sel        = 2'd0;
        manual        = '0;
        busy_man      = '0;
        #1 rst = 1'b1;
        repeat (2) @(negedge clk);

        check("rst_kick", 32'(kick[0]), 0);
        check("rst_read_addr", read_addr[0], 0);
        check("rst_read_num", read_num[0], 0);
        check("rst_cur_fb", 32'(cur_fb[0]), 0);
        check("rst_line_done", 32'(line_done[0]), 0);
        check("rst_frame_done", 32'(frame_done[0]), 0);
        check("rst_overrun", 32'(overrun[0]), 0);
        rst = 1'b0;
        clear();

        // Line 0 on all instances; first kick two cycles after prefetch_line.
        pulse_fs(2'd0);
        pulse_pf();
        check("latency_kick_low", 32'(kick[0]), 0);
        @(negedge clk);
        check("latency_kick_high", 32'(kick[0]), 1);
        wait_ld(0, 1);
        wait_ld(1, 1);
        wait_ld(2, 1);
        check("a_bursts", n_acc[0], 4);
        for (int j = 0; j < 4; j++) begin
            check($sformatf("a_addr%0d", j), cap_addr[0][j], 32'(j * 32'h100));
            check($sformatf("a_num%0d", j), cap_num[0][j], 64);
        end
        check("a_ld_after", ld_after[0], 4);
        check("b_bursts", n_acc[1], 4);
        check("b_num0", cap_num[1][0], 64);
        check("b_num2", cap_num[1][2], 64);
        check("b_num3", cap_num[1][3], 8);
        check("b_addr3", cap_addr[1][3], 32'h300);
        check("b_ld_after", ld_after[1], 4);
        check("c_no_frame_done_yet", n_fd[2], 0);

        // Line 1: last line of the short frame.
        pulse_pf();
        wait_ld(0, 2);
        wait_ld(2, 2);
        check("a_line1_addr", cap_addr[0][4], 32'h400);
        check("c_frame_done", n_fd[2], 1);
        check("c_frame_done_with_line", fd_bad[2], 0);

        // Past the end of the short frame: no kick, no overrun.
        pulse_pf();
        wait_ld(0, 3);
        repeat (5) @(negedge clk);
        check("c_no_extra_burst", n_acc[2], 8);
        check("c_no_extra_line", n_ld[2], 2);
        check("c_overrun_clear", 32'(overrun[2]), 0);

        // Frame buffer 1 selected at framestart.
        clear();
        pulse_fs(2'd1);
        pulse_pf();
        wait_ld(0, 1);
        pulse_pf();
        wait_ld(0, 2);
        check("fb1_line0_addr", cap_addr[0][0], 32'h0010_0000);
        check("fb1_line1_addr", cap_addr[0][4], 32'h0010_0400);
        check("fb1_cur_fb", 32'(cur_fb[0]), 1);
        pulse_fs(2'd2);
        check("fb_clamp", 32'(cur_fb[0]), 1);
        pulse_fs(2'd0);
        check("fb0_cur_fb", 32'(cur_fb[0]), 0);

        // Overrun: second prefetch_line while a burst is pending.
        clear();
        check("overrun_before", 32'(overrun[0]), 0);
        manual[0]   = 1'b1;
        busy_man[0] = 1'b0;
        pulse_pf();
        wait_kick(0);
        pulse_pf();
        check("overrun_set", 32'(overrun[0]), 1);
        check("overrun_kick_held", 32'(kick[0]), 1);
        manual[0] = 1'b0;
        wait_ld(0, 1);
        check("overrun_bursts", n_acc[0], 4);
        check("overrun_sticky", 32'(overrun[0]), 1);

        // framestart while kick is high: one more accept, then idle without line_done.
        clear();
        manual[0]   = 1'b1;
        busy_man[0] = 1'b0;
        pulse_pf();
        wait_kick(0);
        pulse_fs(2'd0);
        check("abort_kick_held", 32'(kick[0]), 1);
        @(negedge clk);
        busy_man[0] = 1'b1;
        @(negedge clk);
        busy_man[0] = 1'b0;
        check("abort_kick_drop", 32'(kick[0]), 0);
        repeat (10) @(negedge clk);
        check("abort_one_accept", n_acc[0], 1);
        check("abort_no_line_done", n_ld[0], 0);
        check("abort_state_idle", 32'(dut_a.state_q), 32'(S_IDLE));

        // Asynchronous reset while waiting for busy to clear.
        busy_man[0] = 1'b1;
        pulse_fs(2'd1);
        pulse_pf();
        @(negedge clk);
        check("wait_state", 32'(dut_a.state_q), 32'(S_WAIT));
        check("wait_cur_fb", 32'(cur_fb[0]), 1);
        check("wait_read_addr", read_addr[0], 32'h0010_0000);
        check("wait_overrun", 32'(overrun[0]), 1);
        #2 rst = 1'b1;
        #1;
        check("async_kick", 32'(kick[0]), 0);
        check("async_read_addr", read_addr[0], 0);
        check("async_read_num", read_num[0], 0);
        check("async_cur_fb", 32'(cur_fb[0]), 0);
        check("async_overrun", 32'(overrun[0]), 0);
        check("async_state", 32'(dut_a.state_q), 32'(S_IDLE));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
